// File: rtl/butterfly_row_buffer.sv
// butterfly_row_buffer
//
// Collects one 8-sample row (x0..x7) of signed, level-shifted pixels, then
// forms the four butterfly pairs x[i]+x[7-i] and x[i]-x[7-i] in a single
// cycle. The pairs are presented to a downstream 4-to-1 selector one index
// at a time under a valid/ready handshake.
//
// Ports
//   clk           system clock, all state updates on its rising edge
//   rst           asynchronous, active-high reset
//   in_valid      in_data carries a valid sample this cycle
//   in_data       signed sample, WIDTH bits, row order x0..x7
//   in_ready      block accepts a sample this cycle (LOAD only)
//   data_I_add_J  signed WIDTH+1 registered sum x[I]+x[J]
//   data_I_sub_J  signed WIDTH+1 registered difference x[I]-x[J]
//   sele          pair index for the downstream selector
//   out_valid     the pair addressed by sele is valid
//   out_ready     downstream consumed the current pair
//   row_done      one-cycle pulse after pair 3 is consumed
module butterfly_row_buffer #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    in_ready,
    output logic signed [WIDTH:0]   data_0_add_7,
    output logic signed [WIDTH:0]   data_1_add_6,
    output logic signed [WIDTH:0]   data_2_add_5,
    output logic signed [WIDTH:0]   data_3_add_4,
    output logic signed [WIDTH:0]   data_0_sub_7,
    output logic signed [WIDTH:0]   data_1_sub_6,
    output logic signed [WIDTH:0]   data_2_sub_5,
    output logic signed [WIDTH:0]   data_3_sub_4,
    output logic [1:0]              sele,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    row_done
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [2:0]              idx;
    logic signed [WIDTH-1:0] x_p0   [8];
    logic signed [WIDTH:0]   sum_p1 [4];
    logic signed [WIDTH:0]   dif_p1 [4];

    // Widen by one bit before add/subtract so every result is exact.
    function automatic logic signed [WIDTH:0] sext(input logic signed [WIDTH-1:0] v);
        return {v[WIDTH-1], v};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (idx == 3'd7)) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                state_nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready && (sele == 2'd3)) begin
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    // Stage p0: sample capture. idx wraps 7 -> 0 on its own, which is
    // exactly the restart point for the next row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                x_p0[i] <= '0;
            end
        end else if ((state == LOAD) && in_valid) begin
            x_p0[idx] <= in_data;
            idx       <= idx + 3'd1;
        end
    end

    // Stage p1: butterfly registers, loaded only on the CALC edge and held
    // through OUT and the following LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                sum_p1[i] <= '0;
                dif_p1[i] <= '0;
            end
        end else if (state == CALC) begin
            for (int i = 0; i < 4; i++) begin
                sum_p1[i] <= sext(x_p0[i]) + sext(x_p0[7-i]);
                dif_p1[i] <= sext(x_p0[i]) - sext(x_p0[7-i]);
            end
        end
    end

    // Pair index and end-of-row pulse. sele wraps 3 -> 0 when the last pair
    // is taken, leaving it at 0 for the next row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sele     <= 2'd0;
            row_done <= 1'b0;
        end else begin
            row_done <= (state == OUT) && out_ready && (sele == 2'd3);
            if (state == CALC) begin
                sele <= 2'd0;
            end else if ((state == OUT) && out_ready) begin
                sele <= sele + 2'd1;
            end
        end
    end

    assign data_0_add_7 = sum_p1[0];
    assign data_1_add_6 = sum_p1[1];
    assign data_2_add_5 = sum_p1[2];
    assign data_3_add_4 = sum_p1[3];
    assign data_0_sub_7 = dif_p1[0];
    assign data_1_sub_6 = dif_p1[1];
    assign data_2_sub_5 = dif_p1[2];
    assign data_3_sub_4 = dif_p1[3];

endmodule
